// File: rtl/ship_sprite_blitter_if.sv
// Request, sprite ROM and framebuffer signals of the ship sprite blitter.
// The blitter takes the master view; the environment takes the slave view.
interface ship_sprite_blitter_if;
    logic        start;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic        erase;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        fb_we;
    logic [9:0]  fb_x;
    logic [9:0]  fb_y;
    logic        fb_data;
    logic        fb_ready;
    logic        busy;
    logic        done;

    modport master (
        input  start, pos_x, pos_y, erase, rom_data, fb_ready,
        output rom_addr, fb_we, fb_x, fb_y, fb_data, busy, done
    );

    modport slave (
        output start, pos_x, pos_y, erase, rom_data, fb_ready,
        input  rom_addr, fb_we, fb_x, fb_y, fb_data, busy, done
    );
endinterface

// File: rtl/ship_sprite_blitter.sv
// Draws a 16-pixel-wide sprite from a combinational ROM into a 1-bit
// framebuffer, one pixel per accepted write, clipping at the screen edge.
module ship_sprite_blitter #(
    parameter int SPRITE_ROWS = 8,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    ship_sprite_blitter_if.master         bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAW,
        S_DONE
    } state_t;

    localparam logic [7:0] LAST_ROW = 8'(SPRITE_ROWS - 1);

    state_t      state_q, state_d;
    logic [7:0]  row_q, row_d;
    logic [3:0]  col_q, col_d;
    logic [9:0]  pos_x_q, pos_x_d;
    logic [9:0]  pos_y_q, pos_y_d;
    logic        erase_q, erase_d;
    logic [15:0] bits_q, bits_d;

    logic [10:0] px;
    logic [10:0] py;
    logic        vis;
    logic        adv;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            pos_x_q <= '0;
            pos_y_q <= '0;
            erase_q <= 1'b0;
            bits_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            erase_q <= erase_d;
            bits_q  <= bits_d;
        end
    end

    // Coordinates are 11 bits wide so sprites hanging off the right or
    // bottom edge compare correctly instead of wrapping.
    always_comb begin
        px  = {1'b0, pos_x_q} + {7'b0, col_q};
        py  = {1'b0, pos_y_q} + {3'b0, row_q};
        vis = (px < 11'(SCREEN_W)) && (py < 11'(SCREEN_H));
        adv = !vis || bus.fb_ready;
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        erase_d = erase_q;
        bits_d  = bits_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    pos_x_d = bus.pos_x;
                    pos_y_d = bus.pos_y;
                    erase_d = bus.erase;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                bits_d  = bus.rom_data;
                col_d   = '0;
                state_d = S_DRAW;
            end
            S_DRAW: begin
                if (adv) begin
                    if (col_q == 4'd15) begin
                        if (row_q == LAST_ROW) begin
                            state_d = S_DONE;
                        end else begin
                            row_d   = row_q + 8'd1;
                            state_d = S_FETCH;
                        end
                    end else begin
                        col_d = col_q + 4'd1;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.rom_addr = '0;
        bus.fb_we    = 1'b0;
        bus.fb_x     = '0;
        bus.fb_y     = '0;
        bus.fb_data  = 1'b0;
        bus.busy     = (state_q != S_IDLE);
        bus.done     = (state_q == S_DONE);
        if (state_q == S_FETCH || state_q == S_DRAW) begin
            bus.rom_addr = row_q;
        end
        // Column 0 is the MSB, so the bit index is 15 - col, i.e. ~col.
        if (state_q == S_DRAW && vis) begin
            bus.fb_we   = 1'b1;
            bus.fb_x    = px[9:0];
            bus.fb_y    = py[9:0];
            bus.fb_data = bits_q[~col_q] & ~erase_q;
        end
    end
endmodule

// File: tb/tb_ship_sprite_blitter.sv
// Randomised bench for ship_sprite_blitter against a pixel-list model.
// Covers reset, clipping, erase, stalls, ignored start and mid-draw reset.
module tb_ship_sprite_blitter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    logic [15:0] rom [0:255];

    ship_sprite_blitter_if b ();

    ship_sprite_blitter #(
        .SPRITE_ROWS(8),
        .SCREEN_W(640),
        .SCREEN_H(480)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(b)
    );

    always #5 clk = ~clk;

    assign b.rom_data = rom[b.rom_addr];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, 32'(b.busy), 32'd0);
        chk({tag, "_done"}, 32'(b.done), 32'd0);
        chk({tag, "_we"}, 32'(b.fb_we), 32'd0);
        chk({tag, "_xyd"}, {b.fb_x, b.fb_y, b.fb_data}, 32'd0);
        chk({tag, "_addr"}, 32'(b.rom_addr), 32'd0);
    endtask

    task automatic run_draw(input logic [9:0] x, input logic [9:0] y,
                            input logic er, input int mode, input bit mid);
        logic [20:0] expq[$];
        logic [20:0] gotq[$];
        logic [20:0] held;
        logic        r;
        bit          hold;
        int          k, stalls, done_k, busy_k;
        for (int rr = 0; rr < 8; rr++) begin
            for (int c = 0; c < 16; c++) begin
                int ax, ay;
                logic [15:0] rw;
                ax = int'(x) + c;
                ay = int'(y) + rr;
                rw = rom[rr];
                if (ax < 640 && ay < 480)
                    expq.push_back({10'(ax), 10'(ay), rw[15-c] & ~er});
            end
        end
        @(negedge clk);
        b.start = 1'b1;
        b.pos_x = x;
        b.pos_y = y;
        b.erase = er;
        @(posedge clk);
        @(negedge clk);
        b.start = 1'b0;
        k = 1;
        stalls = 0;
        done_k = -1;
        busy_k = -1;
        hold = 0;
        held = '0;
        while (k < 3000) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = k[0];
                default: r = 1'($urandom_range(0, 1));
            endcase
            b.fb_ready = r;
            if (mid && k == 40) begin
                b.start = 1'b1;
                b.pos_x = x ^ 10'h155;
                b.pos_y = y ^ 10'h0aa;
                b.erase = ~er;
            end else begin
                b.start = 1'b0;
            end
            #1;
            if (hold)
                chk("stall_hold", {b.fb_we, b.fb_x, b.fb_y, b.fb_data},
                    {1'b1, held});
            hold = 0;
            if (b.fb_we) begin
                if (r) begin
                    gotq.push_back({b.fb_x, b.fb_y, b.fb_data});
                end else begin
                    stalls++;
                    hold = 1;
                    held = {b.fb_x, b.fb_y, b.fb_data};
                end
            end
            if (b.done) done_k = k;
            if (done_k >= 0 && !b.busy) begin
                busy_k = k;
                break;
            end
            @(negedge clk);
            k++;
        end
        b.start = 1'b0;
        chk("timeout", 32'(busy_k >= 0), 32'd1);
        chk("nwrites", gotq.size(), expq.size());
        for (int i = 0; i < gotq.size() && i < expq.size(); i++)
            chk("write", 32'(gotq[i]), 32'(expq[i]));
        chk("done_cycle", done_k, 137 + stalls);
        chk("busy_low", busy_k, 138 + stalls);
        check_idle_outputs("post");
    endtask

    task automatic reset_mid_draw();
        int n;
        bit seen;
        @(negedge clk);
        b.fb_ready = 1'b1;
        b.start = 1'b1;
        b.pos_x = 10'd100;
        b.pos_y = 10'd50;
        b.erase = 1'b0;
        @(negedge clk);
        b.start = 1'b0;
        seen = 0;
        for (n = 0; n < 300; n++) begin
            if (b.fb_we && b.fb_x == 10'd105 && b.fb_y == 10'd53) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        chk("reach_r3c5", 32'(seen), 32'd1);
        rst = 1'b1;
        b.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_idle_outputs("midrst");
        end
        @(negedge clk);
        rst = 1'b0;
        b.start = 1'b1;
        b.pos_x = 10'd20;
        b.pos_y = 10'd30;
        @(posedge clk);
        #1;
        chk("restart_busy", 32'(b.busy), 32'd1);
        chk("restart_addr", 32'(b.rom_addr), 32'd0);
        chk("restart_we", 32'(b.fb_we), 32'd0);
        @(negedge clk);
        b.start = 1'b0;
        @(posedge clk);
        #1;
        chk("restart_px", {b.fb_we, b.fb_x, b.fb_y}, {1'b1, 10'd20, 10'd30});
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_idle_outputs("rst2");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
        rom[1] = 16'h0180;
        b.start = 1'b0;
        b.pos_x = '0;
        b.pos_y = '0;
        b.erase = 1'b0;
        b.fb_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        b.start = 1'b1;
        b.pos_x = 10'd7;
        @(posedge clk);
        #1;
        check_idle_outputs("rst_start");
        @(negedge clk);
        rst = 1'b0;
        b.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("idle");

        run_draw(10'd100, 10'd50, 1'b0, 0, 0);
        run_draw(10'd100, 10'd50, 1'b1, 0, 0);
        run_draw(10'd630, 10'd476, 1'b0, 0, 0);
        run_draw(10'd100, 10'd50, 1'b0, 1, 1);
        for (int i = 0; i < 6; i++)
            run_draw(10'($urandom_range(0, 700)), 10'($urandom_range(0, 500)),
                     1'($urandom), 2, 1'($urandom));
        run_draw(10'd1023, 10'd1023, 1'b0, 0, 0);
        reset_mid_draw();
        run_draw(10'd0, 10'd472, 1'b0, 2, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/ship_sprite_blitter.md
SHIP_SPRITE_BLITTER -- requirements
Module: ship_sprite_blitter

Interface
REQ-001 Parameter SPRITE_ROWS, default 8, number of sprite rows read from the sprite ROM per draw.
REQ-002 Parameter SCREEN_W, default 640, visible framebuffer width in pixels.
REQ-003 Parameter SCREEN_H, default 480, visible framebuffer height in pixels.
REQ-004 Clk  input  1  single clock; every register updates on its rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to draw the sprite; sampled only in IDLE.
REQ-007 pos_x  input  10  left edge of the sprite in pixels; latched when start is accepted.
REQ-008 pos_y  input  10  top edge of the sprite in pixels; latched when start is accepted.
REQ-009 erase  input  1  when latched high, every written pixel is 0; latched when start is accepted.
REQ-010 rom_addr  output  8  row index to the sprite ROM, which is combinational: same-cycle 16-bit row data.
REQ-011 rom_data  input  16  sprite row; bit 15 is the leftmost column (column 0), bit 0 is column 15.
REQ-012 fb_we  output  1  framebuffer pixel write request.
REQ-013 fb_x  output  10  write column.
REQ-014 fb_y  output  10  write row.
REQ-015 fb_data  output  1  pixel value (1 = lit).
REQ-016 fb_ready  input  1  framebuffer accepts the write on any edge where fb_we and fb_ready are both high.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle pulse when a draw completes.

Function
REQ-019 States: IDLE, FETCH, DRAW, DONE; encoding is free.
REQ-020 IDLE: start=1 latches pos_x, pos_y and erase, clears row=0 and col=0, and moves to FETCH; start=0 holds IDLE.
REQ-021 start while busy is ignored: no latching, no queuing, no effect on the current draw.
REQ-022 FETCH: rom_addr=row; the edge latches rom_data into a 16-bit row register, sets col=0 and moves to DRAW; FETCH lasts exactly 1 cycle.
REQ-023 rom_addr: equals the current row index in FETCH and DRAW, and 0 in IDLE and DONE.
REQ-024 DRAW pixel coordinates are computed at 11-bit width: px = pos_x + col, py = pos_y + row.
REQ-025 A pixel is visible only when px < SCREEN_W and py < SCREEN_H.
REQ-026 Visible pixel: fb_we=1, fb_x=px[9:0], fb_y=py[9:0], fb_data = row_reg[15-col] AND NOT erase.
REQ-027 Visible pixel: fb_x, fb_y and fb_data are held stable until the accepting edge (fb_ready=1); col advances only on acceptance.
REQ-028 Clipped (invisible) pixel: fb_we=0; col advances after 1 cycle with no write.
REQ-029 All 16 columns are written, including 0 bits, so a redraw overwrites any previous content.
REQ-030 Leaving col 15: if row = SPRITE_ROWS-1, move to DONE; otherwise row increments and the state moves to FETCH.
REQ-031 DONE: done=1 for exactly 1 cycle, then return to IDLE.
REQ-032 Outside DRAW: fb_we=0, fb_x=0, fb_y=0, fb_data=0.
REQ-033 Latency with fb_ready held 1 and no clipping: start accepted at edge E0, done high in cycle E0+137, busy low from E0+138.
REQ-034 fb_ready stalls extend latency cycle-for-cycle; no write is ever lost or duplicated.

Reset
REQ-035 Reset=1 at an edge forces IDLE with row=0, col=0 and all latched registers 0, overriding start.
REQ-036 Outputs during and after reset: fb_we, fb_x, fb_y, fb_data, busy, done and rom_addr are all 0.
REQ-037 Reset mid-draw aborts the draw: no further fb_we, no done pulse, and start is accepted on the first edge after Reset falls.

Verification
REQ-038 Reset, then pos=(100,50), start, fb_ready=1 -> exactly 128 writes; row 1 (0x0180) is lit only at (107,51) and (108,51); done at E0+137.
REQ-039 erase=1 at (100,50) -> 128 writes, all with fb_data=0, covering x 100..115 and y 50..57.
REQ-040 pos=(630,476) -> writes only for x 630..639 and y 476..479, 40 writes total; done still at E0+137.
REQ-041 fb_ready toggling 1-0 per cycle during a draw -> write sequence identical to REQ-038 and signals stable while stalled; done later by exactly the number of stalled cycles.
REQ-042 Second start pulsed mid-draw, and Reset asserted at draw row 3 col 5 -> second start has no effect; after Reset, fb_we=0, busy=0 and no done pulse.
